// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with mid-bit sampling and one-cycle byte/frame-error strobes
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       Clock,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic       uart_rw,
  output logic [7:0] uart_in,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rxs;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             half_done;
  logic             bit_done;

  // Both stages reset high so a reset never looks like a start bit.
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
    end
  end

  assign half_done = (cnt == HALF_LAST);
  assign bit_done  = (cnt == BIT_LAST);

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!rxs) state_nxt = START;
      end
      START: begin
        if (half_done) state_nxt = rxs ? IDLE : DATA;
      end
      DATA: begin
        if (bit_done && (bit_idx == 3'd7)) state_nxt = STOP;
      end
      // Leaving at the stop-bit midpoint leaves half a bit to catch a back-to-back start.
      STOP: begin
        if (bit_done) state_nxt = rxs ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (rxs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      uart_in   <= 8'h00;
      uart_rw   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      uart_rw   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
        end
        START: begin
          if (half_done) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (rxs) begin
              uart_in <= shreg;
              uart_rw <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - randomized self-checking bench for uart_rx_byte against a frame-level model
module tb_uart_rx_byte;

  localparam int ERR_EV = 256;

  logic       clk;
  logic       rst_n8, rst_n4;
  logic       rxd8, rxd4;
  logic       rw8, rw4;
  logic [7:0] in8, in4;
  logic       err8, err4;
  logic       busy8, busy4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall8 = 0;
  int viol8 = 0, viol4 = 0;
  int last_good8 = 0, last_good4 = 0;

  int exp8[$], got8[$], gcyc8[$];
  int exp4[$], got4[$];

  logic       prev_rw8 = 1'b0, prev_err8 = 1'b0, prev_rst8 = 1'b0;
  logic       prev_rw4 = 1'b0, prev_err4 = 1'b0, prev_rst4 = 1'b0;
  logic [7:0] prev_in8 = 8'h00, prev_in4 = 8'h00;

  uart_rx_byte #(.CLKS_PER_BIT(8), .CNT_W(16)) dut8 (
    .Clock(clk), .rst_n(rst_n8), .uart_rxd(rxd8),
    .uart_rw(rw8), .uart_in(in8), .frame_err(err8), .busy(busy8)
  );

  uart_rx_byte dut4 (
    .Clock(clk), .rst_n(rst_n4), .uart_rxd(rxd4),
    .uart_rw(rw4), .uart_in(in4), .frame_err(err4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every strobe as an event and flag violations of the strobe rules.
  always @(negedge clk) begin
    if (rw8) begin
      got8.push_back(int'(in8));
      gcyc8.push_back(cyc);
    end
    if (err8) got8.push_back(ERR_EV);
    if ((rw8 && err8) || (rw8 && prev_rw8) || (err8 && prev_err8)) viol8++;
    if (!rw8 && in8 !== prev_in8 && rst_n8 && prev_rst8) viol8++;
    prev_rw8 = rw8; prev_err8 = err8; prev_in8 = in8; prev_rst8 = rst_n8;

    if (rw4) got4.push_back(int'(in4));
    if (err4) got4.push_back(ERR_EV);
    if ((rw4 && err4) || (rw4 && prev_rw4) || (err4 && prev_err4)) viol4++;
    if (!rw4 && in4 !== prev_in4 && rst_n4 && prev_rst4) viol4++;
    prev_rw4 = rw4; prev_err4 = err4; prev_in4 = in4; prev_rst4 = rst_n4;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 8) rxd8 = v;
    else rxd4 = v;
  endtask

  // Line is left at the stop value; a low stop bit must be released by the caller.
  task automatic send_frame(input int which, input logic [7:0] b, input int bit_cyc,
                            input int stop_cyc, input logic stop_val);
    if (which == 8) fall8 = cyc;
    set_line(which, 1'b0);
    wait_cyc(bit_cyc);
    for (int i = 0; i < 8; i++) begin
      set_line(which, b[i]);
      wait_cyc(bit_cyc);
    end
    set_line(which, stop_val);
    if (which == 8) begin
      exp8.push_back(stop_val ? int'(b) : ERR_EV);
      if (stop_val) last_good8 = int'(b);
    end else begin
      exp4.push_back(stop_val ? int'(b) : ERR_EV);
      if (stop_val) last_good4 = int'(b);
    end
    wait_cyc(stop_cyc);
  endtask

  task automatic compare_events(input int which, input string tag);
    if (which == 8) begin
      check({tag, "_count"}, got8.size(), exp8.size());
      for (int i = 0; i < exp8.size() && i < got8.size(); i++) check(tag, got8[i], exp8[i]);
      got8.delete(); exp8.delete(); gcyc8.delete();
    end else begin
      check({tag, "_count"}, got4.size(), exp4.size());
      for (int i = 0; i < exp4.size() && i < got4.size(); i++) check(tag, got4[i], exp4[i]);
      got4.delete(); exp4.delete();
    end
  endtask

  initial begin
    logic [7:0] b;
    int         lat;
    int         bad;

    rst_n8 = 1'b0; rst_n4 = 1'b0;
    rxd8 = 1'b1;   rxd4 = 1'b1;
    wait_cyc(5);
    check("reset_rw", int'(rw8), 0);
    check("reset_err", int'(err8), 0);
    check("reset_busy", int'(busy8), 0);
    check("reset_in", int'(in8), 0);
    check("reset_in434", int'(in4), 0);
    rst_n8 = 1'b1; rst_n4 = 1'b1;
    wait_cyc(10);

    // Single frame and start-to-strobe latency.
    send_frame(8, 8'h02, 8, 8, 1'b1);
    wait_cyc(4);
    lat = (gcyc8.size() > 0) ? gcyc8[0] - fall8 : -1;
    check("latency_in_window", int'(lat >= 2 + 4 + 8 * 8 + 8 + 1 - 1 && lat <= 2 + 4 + 8 * 8 + 8 + 1 + 1), 1);
    check("byte_02_in", int'(in8), 8'h02);
    compare_events(8, "t1_events");

    // Back-to-back frames with no idle gap.
    send_frame(8, 8'hA5, 8, 8, 1'b1);
    send_frame(8, 8'h3C, 8, 8, 1'b1);
    send_frame(8, 8'hFF, 8, 8, 1'b1);
    wait_cyc(6);
    compare_events(8, "t2_b2b");

    // Short glitch must be rejected as a false start.
    rxd8 = 1'b0;
    wait_cyc(2);
    rxd8 = 1'b1;
    wait_cyc(20);
    check("glitch_busy_clear", int'(busy8), 0);
    send_frame(8, 8'h55, 8, 8, 1'b1);
    wait_cyc(6);
    compare_events(8, "t3_glitch");

    // Stop bit held low: frame error, busy until line recovers.
    send_frame(8, 8'h81, 8, 24, 1'b0);
    check("break_busy_high", int'(busy8), 1);
    check("break_in_held", int'(in8), last_good8);
    rxd8 = 1'b1;
    wait_cyc(4);
    check("break_busy_low", int'(busy8), 0);
    send_frame(8, 8'h7E, 8, 8, 1'b1);
    wait_cyc(6);
    compare_events(8, "t4_break");

    // Reset during data bit 4 drops the partial frame.
    rxd8 = 1'b0;
    wait_cyc(8);
    for (int i = 0; i < 4; i++) begin
      rxd8 = (8'hC3 >> i) & 1'b1;
      wait_cyc(8);
    end
    rxd8 = 1'b0;
    wait_cyc(4);
    rst_n8 = 1'b0;
    last_good8 = 0;
    wait_cyc(3);
    rxd8 = 1'b1;
    wait_cyc(10);
    rst_n8 = 1'b1;
    wait_cyc(20);
    check("midreset_in", int'(in8), last_good8);
    send_frame(8, 8'h12, 8, 8, 1'b1);
    wait_cyc(6);
    compare_events(8, "t5_reset");

    // Random frames, gaps and broken stop bits.
    for (int k = 0; k < 24; k++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0) ? 1 : 0;
      if (bad == 0) begin
        send_frame(8, b, 8, 8, 1'b1);
        wait_cyc($urandom_range(0, 12));
      end else begin
        send_frame(8, b, 8, 8 * $urandom_range(1, 2), 1'b0);
        rxd8 = 1'b1;
        wait_cyc($urandom_range(3, 12));
      end
    end
    wait_cyc(10);
    check("random_in_last", int'(in8), last_good8);
    compare_events(8, "rand_events");

    // Default divider with transmitter clock +2% and -2%.
    send_frame(4, 8'h00, 443, 443, 1'b1);
    send_frame(4, 8'hFF, 443, 443, 1'b1);
    send_frame(4, 8'h5A, 443, 443, 1'b1);
    wait_cyc(50);
    send_frame(4, 8'h00, 425, 425, 1'b1);
    send_frame(4, 8'hFF, 425, 425, 1'b1);
    send_frame(4, 8'h5A, 425, 425, 1'b1);
    wait_cyc(50);
    check("tol_in_last", int'(in4), last_good4);
    compare_events(4, "tol_events");

    check("strobe_rules_8", viol8, 0);
    check("strobe_rules_434", viol4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
